// File: rtl/interrupt_ctrl_pkg.sv
// Shared definitions for the machine-mode interrupt controller:
// FSM states, cause codes, CSR bit positions and the mtvec mode encoding.
package interrupt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TAKE   = 2'd1,
        ST_VECTOR = 2'd2,
        ST_RET    = 2'd3
    } state_e;

    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIE_MTIE_BIT     = 7;
    localparam int MIE_MEIE_BIT     = 11;
    localparam int MIP_MTIP_BIT     = 7;
    localparam int MIP_MEIP_BIT     = 11;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/interrupt_ctrl.sv
// Machine-mode interrupt entry / mret sequencer: registers pending sources,
// takes traps at writeback and drives CSR writes, flushes and fetch redirects.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_irq,
    input  logic        ext_irq,
    input  logic        mstatus_mie,
    input  logic        mstatus_mpie,
    input  logic        mie_mtie,
    input  logic        mie_meie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_in,
    input  logic [31:0] pc_wb,
    input  logic        wb_valid,
    input  logic        mret,
    output logic        trap,
    output logic        epc_wr,
    output logic [31:0] epc_out,
    output logic        mcause_wr,
    output logic [31:0] mcause_out,
    output logic        mstatus_wr,
    output logic        mie_nxt,
    output logic        mpie_nxt,
    output logic [31:0] mip_out,
    output logic        flush,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic [1:0]  irq_ack
);

    state_e      state_q, state_d;
    logic [3:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic        mie_cap_q, mie_cap_d;
    logic [31:0] mip_q, mip_d;

    logic        ext_en, tmr_en, take, ret;
    logic [31:0] vec_base, vec_target;

    assign ext_en = mip_q[MIP_MEIP_BIT] & mie_meie;
    assign tmr_en = mip_q[MIP_MTIP_BIT] & mie_mtie;
    assign take   = (state_q == ST_IDLE) & wb_valid & mstatus_mie & (ext_en | tmr_en);
    // A simultaneous interrupt squashes the mret; the trap records the mret's PC.
    assign ret    = (state_q == ST_IDLE) & wb_valid & mret & ~take;

    assign vec_base   = {mtvec[31:2], 2'b00};
    assign vec_target = (mtvec[1:0] == MTVEC_MODE_VECTORED)
                      ? vec_base + {26'd0, code_q, 2'b00}
                      : vec_base;

    always_comb begin
        mip_d                = '0;
        mip_d[MIP_MTIP_BIT]  = timer_irq;
        mip_d[MIP_MEIP_BIT]  = ext_irq;
    end

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        epc_d       = epc_q;
        mie_cap_d   = mie_cap_q;
        trap        = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        epc_wr      = 1'b0;
        epc_out     = '0;
        mcause_wr   = 1'b0;
        mcause_out  = '0;
        mstatus_wr  = 1'b0;
        mie_nxt     = 1'b0;
        mpie_nxt    = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        irq_ack     = 2'b00;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d   = ST_TAKE;
                    code_d    = ext_en ? CAUSE_MEI : CAUSE_MTI;
                    epc_d     = pc_wb;
                    mie_cap_d = mstatus_mie;
                end else if (ret) begin
                    state_d = ST_RET;
                end
            end
            ST_TAKE: begin
                trap       = 1'b1;
                stall      = 1'b1;
                flush      = 1'b1;
                epc_wr     = 1'b1;
                epc_out    = epc_q;
                mcause_wr  = 1'b1;
                mcause_out = {1'b1, 27'd0, code_q};
                mstatus_wr = 1'b1;
                mie_nxt    = 1'b0;
                mpie_nxt   = mie_cap_q;
                state_d    = ST_VECTOR;
            end
            ST_VECTOR: begin
                pc_redirect = 1'b1;
                flush       = 1'b1;
                pc_target   = vec_target;
                irq_ack     = (code_q == CAUSE_MEI) ? 2'b10 : 2'b01;
                state_d     = ST_IDLE;
            end
            ST_RET: begin
                mstatus_wr  = 1'b1;
                mie_nxt     = mstatus_mpie;
                mpie_nxt    = 1'b1;
                pc_redirect = 1'b1;
                pc_target   = mepc_in;
                flush       = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            epc_q     <= '0;
            mie_cap_q <= 1'b0;
            mip_q     <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            epc_q     <= epc_d;
            mie_cap_q <= mie_cap_d;
            mip_q     <= mip_d;
        end
    end

    assign mip_out = mip_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl: per-cycle expected outputs are queued as
// stimulus is applied and popped/compared one cycle-sample at a time.
module tb_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        timer_irq, ext_irq, mstatus_mie, mstatus_mpie, mie_mtie, mie_meie;
    logic [31:0] mtvec, mepc_in, pc_wb;
    logic        wb_valid, mret;
    logic        trap, epc_wr, mcause_wr, mstatus_wr, mie_nxt, mpie_nxt;
    logic        flush, stall, pc_redirect;
    logic [31:0] epc_out, mcause_out, mip_out, pc_target;
    logic [1:0]  irq_ack;

    typedef struct packed {
        logic        trap;
        logic        stall;
        logic        flush;
        logic        epc_wr;
        logic [31:0] epc_out;
        logic        mcause_wr;
        logic [31:0] mcause_out;
        logic        mstatus_wr;
        logic        mie_nxt;
        logic        mpie_nxt;
        logic [31:0] mip_out;
        logic        pc_redirect;
        logic [31:0] pc_target;
        logic [1:0]  irq_ack;
    } obs_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    interrupt_ctrl dut (
        .clk(clk), .rst(rst), .timer_irq(timer_irq), .ext_irq(ext_irq),
        .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
        .mie_mtie(mie_mtie), .mie_meie(mie_meie), .mtvec(mtvec), .mepc_in(mepc_in),
        .pc_wb(pc_wb), .wb_valid(wb_valid), .mret(mret), .trap(trap),
        .epc_wr(epc_wr), .epc_out(epc_out), .mcause_wr(mcause_wr),
        .mcause_out(mcause_out), .mstatus_wr(mstatus_wr), .mie_nxt(mie_nxt),
        .mpie_nxt(mpie_nxt), .mip_out(mip_out), .flush(flush), .stall(stall),
        .pc_redirect(pc_redirect), .pc_target(pc_target), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    function automatic obs_t e_idle(input logic [31:0] mip);
        obs_t o = '0;
        o.mip_out = mip;
        return o;
    endfunction

    function automatic obs_t e_take(input logic [31:0] epc, input logic [31:0] cause,
                                    input logic mpie, input logic [31:0] mip);
        obs_t o = '0;
        o.trap = 1'b1; o.stall = 1'b1; o.flush = 1'b1;
        o.epc_wr = 1'b1; o.epc_out = epc;
        o.mcause_wr = 1'b1; o.mcause_out = cause;
        o.mstatus_wr = 1'b1; o.mie_nxt = 1'b0; o.mpie_nxt = mpie;
        o.mip_out = mip;
        return o;
    endfunction

    function automatic obs_t e_vec(input logic [31:0] tgt, input logic [1:0] ack,
                                   input logic [31:0] mip);
        obs_t o = '0;
        o.pc_redirect = 1'b1; o.flush = 1'b1; o.pc_target = tgt; o.irq_ack = ack;
        o.mip_out = mip;
        return o;
    endfunction

    function automatic obs_t e_ret(input logic [31:0] tgt, input logic mie,
                                   input logic [31:0] mip);
        obs_t o = '0;
        o.mstatus_wr = 1'b1; o.mie_nxt = mie; o.mpie_nxt = 1'b1;
        o.pc_redirect = 1'b1; o.pc_target = tgt; o.flush = 1'b1;
        o.mip_out = mip;
        return o;
    endfunction

    task automatic expect_next(input obs_t e);
        exp_q.push_back(e);
    endtask

    task automatic cycle(input string tag);
        obs_t got, e;
        @(posedge clk);
        #1;
        got = '{trap, stall, flush, epc_wr, epc_out, mcause_wr, mcause_out,
                mstatus_wr, mie_nxt, mpie_nxt, mip_out, pc_redirect, pc_target, irq_ack};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty, observed %h", tag, got);
        end else begin
            e = exp_q.pop_front();
            assert (got === e) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, got, e);
            end
        end
    endtask

    initial begin
        rst = 1'b0; timer_irq = 0; ext_irq = 0; mstatus_mie = 0; mstatus_mpie = 0;
        mie_mtie = 0; mie_meie = 0; mtvec = '0; mepc_in = '0; pc_wb = '0;
        wb_valid = 0; mret = 0;

        expect_next(e_idle(32'h0)); cycle("reset0");
        expect_next(e_idle(32'h0)); cycle("reset1");
        rst = 1'b1;

        // timer interrupt, direct mode
        mtvec = 32'h100; mstatus_mie = 1; mie_mtie = 1; timer_irq = 1;
        pc_wb = 32'h40; wb_valid = 1;
        expect_next(e_idle(32'h80)); cycle("t1_mip");
        expect_next(e_take(32'h40, 32'h8000_0007, 1'b1, 32'h80)); cycle("t1_take");
        timer_irq = 0; wb_valid = 0;
        expect_next(e_vec(32'h100, 2'b01, 32'h0)); cycle("t1_vec");
        expect_next(e_idle(32'h0)); cycle("t1_idle");

        // both sources, vectored: external wins
        mtvec = 32'h101; mie_meie = 1; timer_irq = 1; ext_irq = 1;
        pc_wb = 32'h200; wb_valid = 1;
        expect_next(e_idle(32'h880)); cycle("t2_mip");
        expect_next(e_take(32'h200, 32'h8000_000B, 1'b1, 32'h880)); cycle("t2_take");
        timer_irq = 0; ext_irq = 0; wb_valid = 0;
        expect_next(e_vec(32'h12C, 2'b10, 32'h0)); cycle("t2_vec");
        expect_next(e_idle(32'h0)); cycle("t2_idle");

        // globally disabled: pending but no trap
        mstatus_mie = 0; timer_irq = 1; wb_valid = 1; pc_wb = 32'h300;
        expect_next(e_idle(32'h80)); cycle("t3_a");
        expect_next(e_idle(32'h80)); cycle("t3_b");
        timer_irq = 0; wb_valid = 0;
        expect_next(e_idle(32'h0)); cycle("t3_c");

        // mret with MPIE=1, then MPIE=0
        mstatus_mie = 1; mret = 1; wb_valid = 1; mepc_in = 32'h44; mstatus_mpie = 1;
        expect_next(e_ret(32'h44, 1'b1, 32'h0)); cycle("t4_ret");
        mret = 0; wb_valid = 0;
        expect_next(e_idle(32'h0)); cycle("t4_idle");
        mret = 1; wb_valid = 1; mepc_in = 32'h1234; mstatus_mpie = 0;
        expect_next(e_ret(32'h1234, 1'b0, 32'h0)); cycle("t4b_ret");
        mret = 0; wb_valid = 0;
        expect_next(e_idle(32'h0)); cycle("t4b_idle");

        // external pending with wb_valid low, then mret colliding with the take
        mtvec = 32'h100; ext_irq = 1; mepc_in = 32'h44;
        expect_next(e_idle(32'h800)); cycle("t5_blocked");
        wb_valid = 1; mret = 1; pc_wb = 32'h80;
        expect_next(e_take(32'h80, 32'h8000_000B, 1'b1, 32'h800)); cycle("t5_take");
        ext_irq = 0; wb_valid = 0; mret = 0;
        expect_next(e_vec(32'h100, 2'b10, 32'h0)); cycle("t5_vec");
        expect_next(e_idle(32'h0)); cycle("t5_idle");

        // held source is not re-taken during VECTOR; reset during VECTOR and TAKE
        timer_irq = 1; wb_valid = 1; pc_wb = 32'h500;
        expect_next(e_idle(32'h80)); cycle("t6_mip");
        expect_next(e_take(32'h500, 32'h8000_0007, 1'b1, 32'h80)); cycle("t6_take");
        expect_next(e_vec(32'h100, 2'b01, 32'h80)); cycle("t6_vec");
        rst = 0;
        expect_next(e_idle(32'h0)); cycle("t6_rst_vec");
        rst = 1;
        expect_next(e_idle(32'h80)); cycle("t6_rel");
        expect_next(e_take(32'h500, 32'h8000_0007, 1'b1, 32'h80)); cycle("t6_take2");
        rst = 0;
        expect_next(e_idle(32'h0)); cycle("t6_rst_take");
        rst = 1; timer_irq = 0; wb_valid = 0;
        expect_next(e_idle(32'h0)); cycle("t6_quiet");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-003 SHALL: timer_irq, ext_irq  input  1 each  level interrupt sources.
REQ-004 SHALL: mstatus_mie, mstatus_mpie  input  1 each  current mstatus[3], mstatus[7] from CSR file.
REQ-005 SHALL: mie_mtie, mie_meie  input  1 each  current mie[7], mie[11].
REQ-006 SHALL: mtvec  input  32  trap vector; [1:0]=01 vectored, else direct.
REQ-007 SHALL: mepc_in  input  32  current mepc from CSR file.
REQ-008 SHALL: pc_wb  input  32, wb_valid  input  1: PC and valid flag of oldest uncommitted instruction.
REQ-009 SHALL: mret  input  1  mret decoded in writeback (qualified by wb_valid).
REQ-010 SHALL: trap  output  1  trap indication to CSR file.
REQ-011 SHALL: epc_wr  output  1, epc_out  output  32: mepc write port.
REQ-012 SHALL: mcause_wr  output  1, mcause_out  output  32: mcause write port.
REQ-013 SHALL: mstatus_wr  output  1, mie_nxt, mpie_nxt  output  1 each: mstatus MIE/MPIE update.
REQ-014 SHALL: mip_out  output  32  pending bits (MTIP bit 7, MEIP bit 11, others 0).
REQ-015 SHALL: flush, stall  output  1 each  pipeline control.
REQ-016 SHALL: pc_redirect  output  1, pc_target  output  32: fetch redirect.
REQ-017 SHALL: irq_ack  output  2  one-hot ack, [0]=timer, [1]=external.

Function
REQ-018 SHALL: register timer_irq/ext_irq into mip_out every cycle in every state (1-cycle latency).
REQ-019 SHALL: FSM states IDLE, TAKE, VECTOR, RET; encoding 2 bits.
REQ-020 SHALL: take = IDLE & wb_valid & mstatus_mie & ((mip[11]&mie_meie) | (mip[7]&mie_mtie)).
REQ-021 SHALL: priority external (code 11) over timer (code 7); code latched on IDLE->TAKE.
REQ-022 SHALL: IDLE->TAKE on take; TAKE outputs for exactly one cycle: trap=1, stall=1, flush=1, epc_wr=1 with epc_out=pc_wb captured at take, mcause_wr=1 with mcause_out={1'b1,27'b0,code[3:0]}, mstatus_wr=1 with mie_nxt=0, mpie_nxt=captured mstatus_mie.
REQ-023 SHALL: TAKE->VECTOR unconditionally; VECTOR outputs one cycle: pc_redirect=1, flush=1, irq_ack one-hot for taken source; pc_target={mtvec[31:2],2'b00} direct, {mtvec[31:2],2'b00}+4*code vectored (32-bit wrap, no overflow flag).
REQ-024 SHALL: VECTOR->IDLE unconditionally; total interrupt entry latency 2 cycles after take.
REQ-025 SHALL: IDLE->RET on wb_valid & mret & ~take; RET outputs one cycle: mstatus_wr=1, mie_nxt=mstatus_mpie, mpie_nxt=1, pc_redirect=1, pc_target=mepc_in, flush=1; RET->IDLE.
REQ-026 SHALL: interrupt and mret in same cycle: interrupt wins, mret squashed, epc_out=pc_wb of mret.
REQ-027 SHALL: no take/mret evaluation outside IDLE; pending sources stay visible in mip_out and are evaluated on return to IDLE.
REQ-028 SHALL: wb_valid=0 blocks take and mret.
REQ-029 SHALL: all pulse outputs 0 in IDLE when no event.

Reset
REQ-030 SHALL: rst=0 at posedge -> state IDLE, mip_out=0, latched code/PC=0, all outputs 0 next cycle, including mid-TAKE/VECTOR/RET (no partial redirect).

Structure
REQ-031 SHALL: shared package holds state enum, cause codes (7, 11), mstatus/mie/mip bit indices, mtvec mode constant.
REQ-032 SHALL: single module, no sub-modules; vector target via combinational adder.

Verification
REQ-033 SHALL: mtvec=0x100 direct, MIE=1, MTIE=1, timer_irq=1, pc_wb=0x40 -> mepc=0x40, mcause=0x80000007, pc_target=0x100, irq_ack=01.
REQ-034 SHALL: mtvec=0x101 vectored, both irqs, both enables -> mcause=0x8000000B, pc_target=0x12C, irq_ack=10.
REQ-035 SHALL: MIE=0, timer_irq=1 -> no trap, mip_out=0x80.
REQ-036 SHALL: mret, mepc_in=0x44, MPIE=1 -> pc_target=0x44, mie_nxt=1, mpie_nxt=1, one-cycle RET.
REQ-037 SHALL: mret and ext take same cycle, pc_wb=0x80 -> TAKE path, epc_out=0x80, no RET.
REQ-038 SHALL: rst=0 during VECTOR -> pc_redirect=0 next cycle, state IDLE.
